// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between the I-cache refill port and
// the D-cache port; D is favoured up to a streak limit, every access has an ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_streak;

  logic w_i_ok, w_d_ok, w_d_win, w_finish;

  // A requester whose done is still high is holding a stale request; skip it once.
  assign w_i_ok   = i_req && !i_done;
  assign w_d_ok   = d_req && !d_done;
  assign w_d_win  = w_d_ok && (!w_i_ok || (r_streak < STREAK_MAX));
  assign w_finish = mem_ack || (r_timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_streak    <= '0;
      i_done      <= 1'b0;
      i_rdata     <= '0;
      d_done      <= 1'b0;
      d_rdata     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_d_win) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            r_timer   <= '0;
            r_state   <= S_BUSY_D;
            if (!w_i_ok)                      r_streak <= '0;
            else if (r_streak != STREAK_MAX)  r_streak <= r_streak + SW'(1);
          end else if (w_i_ok) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            r_timer   <= '0;
            r_streak  <= '0;
            r_state   <= S_BUSY_I;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (w_finish) begin
            mem_req     <= 1'b0;
            err_timeout <= !mem_ack;
            r_state     <= S_IDLE;
            if (r_state == S_BUSY_I) begin
              i_done  <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_done <= 1'b1;
              // A completed write leaves the last read data in place.
              if (!mem_ack)    d_rdata <= '0;
              else if (!mem_we) d_rdata <= mem_rdata;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: random I/D requesters, a random
// memory (latency, timeouts, spurious acks) and a rule-level arbitration/data model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_done, d_done, mem_req, mem_we, err_timeout;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {bit port; logic [31:0] rdata; bit err;} exp_t;  // port: 1=D
  exp_t q[$];

  int total = 0, bad = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] mem_arr [16];
  logic [31:0] ref_d_rdata;
  int          ref_streak;
  bit          mem_hold;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {25'd0, mem_req, mem_we, i_done, d_done, err_timeout, 2'b00}, 32'd0);
    chk({nm, "_maddr"}, mem_addr, 32'd0);
    chk({nm, "_mwdata"}, mem_wdata, 32'd0);
    chk({nm, "_irdata"}, i_rdata, 32'd0);
    chk({nm, "_drdata"}, d_rdata, 32'd0);
  endtask

  // Mid-cycle snapshot: equals what the DUT samples at the next rising edge.
  bit          s_valid, s_i_req, s_i_done, s_d_req, s_d_done, s_d_we;
  logic [31:0] s_i_addr, s_d_addr, s_d_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_valid = 1'b0;
    end else begin
      if (i_done || d_done) begin
        chk("done_exclusive", 32'(i_done & d_done), 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_done", {30'd0, i_done, d_done}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_port", 32'(d_done), 32'(e.port));
          chk("done_rdata", d_done ? d_rdata : i_rdata, e.rdata);
          chk("done_err", 32'(err_timeout), 32'(e.err));
        end
      end else if (err_timeout) begin
        chk("err_without_done", 32'(err_timeout), 32'd0);
      end
      s_valid = 1'b1;
      s_i_req = i_req;  s_i_done = i_done; s_i_addr = i_addr;
      s_d_req = d_req;  s_d_done = d_done; s_d_we = d_we;
      s_d_addr = d_addr; s_d_wdata = d_wdata;
    end
  end

  // Memory model plus arbitration reference; pushes the expected completion per grant.
  bit          busy, prev_req, no_ack;
  int          cnt, wait_n;
  logic [31:0] a_addr, a_wdata;
  bit          a_we;

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      busy = 0; prev_req = 0; mem_ack = 1'b0; mem_rdata = '0;
    end else begin
      bit iok, dok, dwin;
      iok  = s_valid && s_i_req && !s_i_done;
      dok  = s_valid && s_d_req && !s_d_done;
      dwin = dok && (!iok || ref_streak < MAXS);
      if (!prev_req && (iok || dok)) chk("grant_issued", 32'(mem_req), 32'd1);
      if (mem_req && !busy) begin
        exp_t e;
        chk("grant_legal", 32'(mem_req), 32'(iok || dok));
        chk("grant_we", 32'(mem_we), 32'(dwin && s_d_we));
        chk("grant_addr", mem_addr, dwin ? s_d_addr : s_i_addr);
        chk("grant_wdata", mem_wdata, dwin ? s_d_wdata : 32'd0);
        busy = 1; cnt = 0;
        no_ack = mem_hold || ($urandom_range(0, 5) == 0);
        wait_n = $urandom_range(0, 3);
        a_addr = mem_addr; a_we = mem_we; a_wdata = mem_wdata;
        e.port = dwin; e.err = no_ack; e.rdata = '0;
        if (!no_ack) begin
          if (!dwin)      e.rdata = ref_mem[s_i_addr[3:0]];
          else if (!s_d_we) e.rdata = ref_mem[s_d_addr[3:0]];
          else begin
            e.rdata = ref_d_rdata;
            ref_mem[s_d_addr[3:0]] = s_d_wdata;
          end
        end
        if (dwin) begin
          ref_d_rdata = e.rdata;
          ref_streak  = iok ? ((ref_streak < MAXS) ? ref_streak + 1 : MAXS) : 0;
        end else begin
          ref_streak = 0;
        end
        q.push_back(e);
      end
      if (mem_req) begin
        chk("hold_fields", mem_addr ^ mem_wdata ^ 32'(mem_we), a_addr ^ a_wdata ^ 32'(a_we));
        cnt++;
        if (!no_ack && cnt > wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = a_we ? $urandom : mem_arr[a_addr[3:0]];
          if (a_we) mem_arr[a_addr[3:0]] = a_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (busy) begin
          chk("req_cycles", cnt, no_ack ? TO : wait_n + 1);
          busy = 0;
        end
        mem_ack   = ($urandom_range(0, 9) == 0);
        mem_rdata = $urandom;
      end
      prev_req = mem_req;
    end
  end

  task automatic drive_i(input int n);
    int cyc; bit keep;
    keep = 0;
    for (int k = 0; k < n; k++) begin
      if (!keep) repeat ($urandom_range(0, 4)) begin @(posedge clk); #2; end
      i_addr = $urandom_range(0, 15);
      i_req  = 1'b1;
      cyc = 0;
      do begin @(posedge clk); #2; cyc++; end while (!i_done && cyc < 100);
      if (!i_done) chk("i_done_timely", 32'(i_done), 32'd1);
      keep = ($urandom_range(0, 2) == 0);
      if (!keep) i_req = 1'b0;
    end
    i_req = 1'b0;
  endtask

  task automatic drive_d(input int n);
    int cyc; bit keep;
    keep = 0;
    for (int k = 0; k < n; k++) begin
      if (!keep) repeat ($urandom_range(0, 4)) begin @(posedge clk); #2; end
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom_range(0, 15);
      d_wdata = $urandom;
      d_req   = 1'b1;
      cyc = 0;
      do begin @(posedge clk); #2; cyc++; end while (!d_done && cyc < 100);
      if (!d_done) chk("d_done_timely", 32'(d_done), 32'd1);
      keep = ($urandom_range(0, 2) == 0);
      if (!keep) d_req = 1'b0;
    end
    d_req = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 32'(a) * 32'h9E3779B1 + 32'h1234;
      mem_arr[a] = ref_mem[a];
    end
    ref_d_rdata = '0; ref_streak = 0; mem_hold = 1'b1;
    rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset_initial");
    @(negedge clk); #3 rst_n = 1'b1;

    // Reset in the middle of a D write that the memory never acknowledges.
    @(posedge clk); #2;
    d_we = 1'b1; d_addr = 32'h3; d_wdata = 32'h55; d_req = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #2; cyc++; end while (!mem_req && cyc < 20);
    chk("reset_test_grant", 32'(mem_req), 32'd1);
    @(posedge clk); @(negedge clk); #3;
    rst_n = 1'b0;
    #1 chk_reset_outputs("reset_mid_busy");
    q.delete(); ref_streak = 0; ref_d_rdata = '0;
    d_req = 1'b0; d_we = 1'b0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3 rst_n = 1'b1;

    @(posedge clk); #2;
    fork
      drive_i(80);
      drive_d(80);
    join
    repeat (20) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
